// File: rtl/led_matrix_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : led_matrix_scan_driver
// Description : Row-multiplexed 8x8 LED matrix driver. A valid/ready write
//               port fills the back bank of a double-buffered frame store.
//               The front bank is scanned one row at a time, with blanking
//               between rows and 8-level PWM brightness. Bank swaps happen
//               only at frame boundaries, so a frame is never torn.
// Revision    : 1.0 - initial release
// ============================================================================
module led_matrix_scan_driver #(
    parameter int DWELL_CYCLES = 64,   // cycles each row is driven (multiple of 8)
    parameter int BLANK_CYCLES = 4     // all-off cycles ahead of each row (>= 1)
) (
    input  logic       row_clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_row,
    input  logic [7:0] wr_data,
    input  logic       wr_last,
    input  logic [2:0] brightness,
    output logic [7:0] row_drv,
    output logic [7:0] col_drv,
    output logic [2:0] scan_row,
    output logic       frame_done
);

    // One counter serves both the blank and the dwell windows, so it is sized
    // for the longer of the two; it must also hold the full-duty threshold.
    localparam int c_cnt_max = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam int c_step    = DWELL_CYCLES / 8;   // dwell cycles per brightness level

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2
    } state_t;

    state_t               state_q,        state_d;
    logic [2:0]           scan_row_q,     scan_row_d;
    logic [c_cnt_w-1:0]   cnt_q,          cnt_d;
    logic [7:0]           pattern_q,      pattern_d;
    logic [c_cnt_w-1:0]   thresh_q,       thresh_d;
    logic                 bank_sel_q,     bank_sel_d;
    logic                 swap_pending_q, swap_pending_d;
    logic [7:0]           bank_q [2][8];
    logic [7:0]           bank_d [2][8];
    logic [7:0]           row_drv_q,      row_drv_d;
    logic [7:0]           col_drv_q,      col_drv_d;
    logic                 frame_done_q,   frame_done_d;

    logic                 w_wr_fire;
    logic                 w_frame_wrap;

    // Writes are refused while a completed frame waits for its swap, and
    // while reset is held.
    assign wr_ready  = ~swap_pending_q & ~reset;
    assign w_wr_fire = wr_valid & wr_ready;

    assign row_drv    = row_drv_q;
    assign col_drv    = col_drv_q;
    assign scan_row   = scan_row_q;
    assign frame_done = frame_done_q;

    // Next-state logic: write port, scan FSM, frame-boundary swap, and the
    // output image derived from the next state so outputs stay registered.
    always_comb begin
        state_d        = state_q;
        scan_row_d     = scan_row_q;
        cnt_d          = cnt_q;
        pattern_d      = pattern_q;
        thresh_d       = thresh_q;
        bank_sel_d     = bank_sel_q;
        swap_pending_d = swap_pending_q;
        bank_d         = bank_q;
        row_drv_d      = 8'hFF;
        col_drv_d      = 8'h00;
        frame_done_d   = 1'b0;
        w_frame_wrap   = 1'b0;

        // Write beats always land in the back bank (the one not on display).
        if (w_wr_fire) begin
            bank_d[~bank_sel_q][wr_row] = wr_data;
            if (wr_last) begin
                swap_pending_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d    = ST_BLANK;
                    cnt_d      = '0;
                    scan_row_d = 3'd0;
                end
            end
            ST_BLANK: begin
                if (cnt_q == c_cnt_w'(BLANK_CYCLES - 1)) begin
                    // Snapshot row data and duty here so mid-row changes wait
                    // for the next row.
                    state_d   = ST_ON;
                    cnt_d     = '0;
                    pattern_d = bank_q[bank_sel_q][scan_row_q];
                    thresh_d  = c_cnt_w'((int'(brightness) + 1) * c_step);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ON: begin
                if (cnt_q == c_cnt_w'(DWELL_CYCLES - 1)) begin
                    state_d    = ST_BLANK;
                    cnt_d      = '0;
                    scan_row_d = scan_row_q + 3'd1;
                    if (scan_row_q == 3'd7) begin
                        w_frame_wrap = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Disabling darkens the matrix at once; a pending swap is kept.
        if (!enable) begin
            state_d      = ST_IDLE;
            cnt_d        = '0;
            scan_row_d   = 3'd0;
            w_frame_wrap = 1'b0;
        end

        // Only a swap already pending before the boundary cycle is honoured;
        // wr_ready is low whenever one is pending, so no beat can collide.
        if (w_frame_wrap) begin
            frame_done_d = 1'b1;
            if (swap_pending_q) begin
                bank_sel_d     = ~bank_sel_q;
                swap_pending_d = 1'b0;
            end
        end

        if (state_d == ST_ON) begin
            row_drv_d = ~(8'h01 << scan_row_d);
            if (cnt_d < thresh_d) begin
                col_drv_d = pattern_d;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge row_clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            scan_row_q     <= 3'd0;
            cnt_q          <= '0;
            pattern_q      <= 8'h00;
            thresh_q       <= '0;
            bank_sel_q     <= 1'b0;
            swap_pending_q <= 1'b0;
            row_drv_q      <= 8'hFF;
            col_drv_q      <= 8'h00;
            frame_done_q   <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < 8; r++) begin
                    bank_q[b][r] <= 8'h00;
                end
            end
        end else begin
            state_q        <= state_d;
            scan_row_q     <= scan_row_d;
            cnt_q          <= cnt_d;
            pattern_q      <= pattern_d;
            thresh_q       <= thresh_d;
            bank_sel_q     <= bank_sel_d;
            swap_pending_q <= swap_pending_d;
            row_drv_q      <= row_drv_d;
            col_drv_q      <= col_drv_d;
            frame_done_q   <= frame_done_d;
            bank_q         <= bank_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_matrix_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_matrix_scan_driver
// Description : Self-checking bench for led_matrix_scan_driver: table-driven
//               brightness/pattern vectors plus hand-written sequences for
//               swap timing, enable drop and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_matrix_scan_driver;

    localparam int DWELL = 64;
    localparam int BLANK = 4;
    localparam int ROWP  = DWELL + BLANK;   // 68
    localparam int FRAME = 8 * ROWP;        // 544

    logic       row_clk;
    logic       reset;
    logic       enable;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_row;
    logic [7:0] wr_data;
    logic       wr_last;
    logic [2:0] brightness;
    logic [7:0] row_drv;
    logic [7:0] col_drv;
    logic [2:0] scan_row;
    logic       frame_done;

    int errors = 0;
    int checks = 0;

    led_matrix_scan_driver #(
        .DWELL_CYCLES (DWELL),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .row_clk    (row_clk),
        .reset      (reset),
        .enable     (enable),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_row     (wr_row),
        .wr_data    (wr_data),
        .wr_last    (wr_last),
        .brightness (brightness),
        .row_drv    (row_drv),
        .col_drv    (col_drv),
        .scan_row   (scan_row),
        .frame_done (frame_done)
    );

    initial row_clk = 1'b0;
    always #5 row_clk = ~row_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0] bright;
        logic [7:0] pat;
        int         exp_on;    // col_drv-active cycles in one ON window
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Step up to 2000 cycles until frame_done is seen; returns the step count.
    task automatic wait_fd(input string name, output int cycles);
        cycles = 0;
        do begin
            @(negedge row_clk);
            cycles++;
        end while (frame_done !== 1'b1 && cycles < 2000);
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL %s: frame_done not seen within %0d cycles, expected a pulse", name, cycles);
        end
    endtask

    // Model of one frame from the row-0 blank onward. Must be entered at the
    // negedge of frame cycle k0 (k=1 is the first blank cycle of row 0).
    task automatic check_frame(input int k0, input logic [7:0] pats [8],
                               input logic [2:0] bright, input logic fd_first,
                               input string name, output int row0_on);
        int         err [8];
        int         first_k [8];
        logic [7:0] got_r [8];
        logic [7:0] got_c [8];
        logic [7:0] exp_r [8];
        logic [7:0] exp_c [8];
        logic [7:0] er, ec;
        logic [2:0] es;
        logic       ef;
        int         r, p;
        row0_on = 0;
        for (int i = 0; i < 8; i++) begin
            err[i] = 0; first_k[i] = 0;
            got_r[i] = 0; got_c[i] = 0; exp_r[i] = 0; exp_c[i] = 0;
        end
        for (int k = k0; k <= FRAME; k++) begin
            if (k > k0) @(negedge row_clk);
            r  = (k - 1) / ROWP;
            p  = (k - 1) % ROWP;
            ef = (k == 1) ? fd_first : 1'b0;
            es = r[2:0];
            if (p < BLANK) begin
                er = 8'hFF;
                ec = 8'h00;
            end else begin
                er = ~(8'h01 << r);
                ec = ((p - BLANK) < (int'(bright) + 1) * (DWELL / 8)) ? pats[r] : 8'h00;
            end
            if (r == 0 && col_drv != 8'h00) row0_on++;
            if (row_drv !== er || col_drv !== ec || scan_row !== es || frame_done !== ef) begin
                if (err[r] == 0) begin
                    first_k[r] = k;
                    got_r[r] = row_drv; got_c[r] = col_drv;
                    exp_r[r] = er;      exp_c[r] = ec;
                end
                err[r]++;
            end
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (err[i] != 0) begin
                errors++;
                $display("FAIL %s row %0d: %0d bad cycles (first k=%0d row_drv=%h col_drv=%h, expected row_drv=%h col_drv=%h)",
                         name, i, err[i], first_k[i], got_r[i], got_c[i], exp_r[i], exp_c[i]);
            end
        end
    endtask

    // Write rows 0..n-1, one beat per cycle; optionally flag the final beat.
    task automatic write_rows(input logic [7:0] pats [8], input int n, input logic last);
        for (int i = 0; i < n; i++) begin
            chk("wr_ready before beat", {31'd0, wr_ready}, 32'd1);
            wr_valid = 1'b1;
            wr_row   = i[2:0];
            wr_data  = pats[i];
            wr_last  = last && (i == n - 1);
            @(negedge row_clk);
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        if (last) chk("wr_ready low after wr_last", {31'd0, wr_ready}, 32'd0);
    endtask

    initial begin
        vec_t       vecs [4];
        logic [7:0] zeros [8];
        logic [7:0] p2 [8];
        logic [7:0] pv [8];
        logic [7:0] p4 [8];
        logic [7:0] p6 [8];
        logic [7:0] old [8];
        int         cyc;
        int         on;

        vecs[0] = '{bright: 3'd0, pat: 8'hFF, exp_on: 8};
        vecs[1] = '{bright: 3'd7, pat: 8'hFF, exp_on: 64};
        vecs[2] = '{bright: 3'd3, pat: 8'hA5, exp_on: 32};
        vecs[3] = '{bright: 3'd1, pat: 8'h3C, exp_on: 16};
        zeros = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        p2    = '{8'h81, 8'hC3, 8'hE7, 8'hFF, 8'hFF, 8'hE7, 8'hC3, 8'h81};
        p4    = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        p6    = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55};

        reset = 1'b1; enable = 1'b0; wr_valid = 1'b0; wr_row = 3'd0;
        wr_data = 8'h00; wr_last = 1'b0; brightness = 3'd7;

        // ---- Reset state ----
        repeat (3) @(negedge row_clk);
        chk("reset row_drv",    {24'd0, row_drv},    32'hFF);
        chk("reset col_drv",    {24'd0, col_drv},    32'h00);
        chk("reset frame_done", {31'd0, frame_done}, 32'd0);
        chk("reset scan_row",   {29'd0, scan_row},   32'd0);
        chk("reset wr_ready",   {31'd0, wr_ready},   32'd0);
        reset = 1'b0;
        @(negedge row_clk);
        chk("idle wr_ready", {31'd0, wr_ready}, 32'd1);
        chk("idle row_drv",  {24'd0, row_drv},  32'hFF);

        // ---- Test 1: empty banks, scan timing and frame period ----
        enable = 1'b1;
        @(negedge row_clk);
        check_frame(1, zeros, 3'd7, 1'b0, "t1 empty frame", on);
        wait_fd("t1 first frame_done", cyc);
        chk("t1 first frame_done latency", cyc, 32'd1);
        wait_fd("t1 second frame_done", cyc);
        chk("t1 frame period", cyc, FRAME);

        // ---- Test 2: full frame write, swap at next boundary ----
        write_rows(p2, 8, 1'b1);
        wait_fd("t2 swap boundary", cyc);
        chk("t2 wr_ready at frame_done", {31'd0, wr_ready}, 32'd1);
        check_frame(1, p2, 3'd7, 1'b1, "t2 new frame", on);

        // ---- Test 3: brightness/pattern table ----
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < 8; i++) pv[i] = vecs[v].pat;
            brightness = vecs[v].bright;
            write_rows(pv, 8, 1'b1);
            wait_fd("t3 swap boundary", cyc);
            chk("t3 wr_ready at frame_done", {31'd0, wr_ready}, 32'd1);
            check_frame(1, pv, vecs[v].bright, 1'b1, "t3 vector frame", on);
            chk("t3 row0 lit cycles", on, vecs[v].exp_on);
        end

        // ---- Test 4: wr_last accepted in the frame_done cycle ----
        for (int i = 0; i < 8; i++) old[i] = 8'h3C;
        brightness = 3'd7;
        write_rows(p4, 7, 1'b0);
        wait_fd("t4 boundary A", cyc);
        chk("t4 wr_ready at boundary A", {31'd0, wr_ready}, 32'd1);
        wr_valid = 1'b1; wr_row = 3'd7; wr_data = p4[7]; wr_last = 1'b1;
        check_frame(1, old, 3'd7, 1'b1, "t4 no-swap frame", on);
        chk("t4 wr_ready still low", {31'd0, wr_ready}, 32'd0);
        wr_valid = 1'b0; wr_last = 1'b0;
        wait_fd("t4 boundary B", cyc);
        chk("t4 boundary B latency", cyc, 32'd1);
        chk("t4 wr_ready after swap", {31'd0, wr_ready}, 32'd1);
        check_frame(1, p4, 3'd7, 1'b1, "t4 swapped frame", on);

        // ---- Test 5: enable dropped mid-ON on row 3 ----
        @(negedge row_clk);
        chk("t5 frame_done", {31'd0, frame_done}, 32'd1);
        for (int k = 1; k < 3 * ROWP + BLANK + 11; k++) @(negedge row_clk);
        chk("t5 row3 driven",  {24'd0, row_drv}, 32'hF7);
        chk("t5 row3 columns", {24'd0, col_drv}, 32'h08);
        enable = 1'b0;
        @(negedge row_clk);
        chk("t5 dark row_drv",    {24'd0, row_drv},    32'hFF);
        chk("t5 dark col_drv",    {24'd0, col_drv},    32'h00);
        chk("t5 dark scan_row",   {29'd0, scan_row},   32'd0);
        chk("t5 dark frame_done", {31'd0, frame_done}, 32'd0);
        repeat (3) @(negedge row_clk);
        chk("t5 still dark", {24'd0, row_drv}, 32'hFF);
        enable = 1'b1;
        @(negedge row_clk);
        check_frame(1, p4, 3'd7, 1'b0, "t5 restart frame", on);

        // ---- Test 6: reset with a pending swap ----
        write_rows(p6, 8, 1'b1);
        repeat (20) @(negedge row_clk);
        reset = 1'b1;
        @(negedge row_clk);
        chk("t6 reset row_drv",  {24'd0, row_drv},  32'hFF);
        chk("t6 reset col_drv",  {24'd0, col_drv},  32'h00);
        chk("t6 reset scan_row", {29'd0, scan_row}, 32'd0);
        chk("t6 reset wr_ready", {31'd0, wr_ready}, 32'd0);
        @(negedge row_clk);
        chk("t6 reset wr_ready held", {31'd0, wr_ready}, 32'd0);
        reset = 1'b0;
        @(negedge row_clk);
        chk("t6 wr_ready after reset", {31'd0, wr_ready}, 32'd1);
        check_frame(1, zeros, 3'd7, 1'b0, "t6 first frame", on);
        @(negedge row_clk);
        check_frame(1, zeros, 3'd7, 1'b1, "t6 second frame", on);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
